// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_ctrl
// Purpose  : Control sequencer for the ALU datapath. Issues the c0..c7
//            strobes for add, sub and radix-2 Booth signed multiply over
//            WIDTH-bit operands. The A/Q/Q[-1]/M datapath lives outside this
//            block and returns its Booth bit pair {Q[0], Q[-1]}.
// Ports    : clk, rst (sync, active high), en (freeze when low),
//            start/op (command, sampled in IDLE), booth_bits (from datapath),
//            c0..c7 (datapath strobes), busy, done (1-cycle pulse),
//            state/cnt (debug view of FSM state and Booth iteration index).
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [1:0]       booth_bits,
    output logic             c0,
    output logic             c1,
    output logic             c2,
    output logic             c3,
    output logic             c4,
    output logic             c5,
    output logic             c6,
    output logic             c7,
    output logic             busy,
    output logic             done,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_LOAD_M = 3'd1;
    localparam logic [2:0] c_LOAD_Q = 3'd2;
    localparam logic [2:0] c_EVAL   = 3'd3;
    localparam logic [2:0] c_SHIFT  = 3'd4;
    localparam logic [2:0] c_OUT_HI = 3'd5;
    localparam logic [2:0] c_OUT_LO = 3'd6;

    localparam logic [1:0] c_OP_SUB  = 2'b01;
    localparam logic [1:0] c_OP_MUL  = 2'b10;
    localparam logic [1:0] c_OP_RSVD = 2'b11;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       r_op;
    logic             w_accept;
    logic             w_is_mul;

    // A command is taken only from IDLE; reserved opcode is silently dropped.
    assign w_accept = (r_state == c_IDLE) && start && (op != c_OP_RSVD);
    assign w_is_mul = (r_op == c_OP_MUL);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_IDLE: begin
                if (w_accept) w_state_nxt = c_LOAD_M;
            end
            c_LOAD_M: w_state_nxt = c_LOAD_Q;
            c_LOAD_Q: begin
                if (w_is_mul) begin
                    w_state_nxt = c_EVAL;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = c_OUT_LO;
                end
            end
            c_EVAL:   w_state_nxt = c_SHIFT;
            c_SHIFT: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_OUT_HI;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                    w_state_nxt = c_EVAL;
                end
            end
            c_OUT_HI: w_state_nxt = c_OUT_LO;
            c_OUT_LO: w_state_nxt = c_IDLE;
            default:  w_state_nxt = c_IDLE;  // encoding 7 recovers to IDLE
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_op    <= 2'b00;
        end else if (en) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) r_op <= op;
        end
    end

    // Strobes are a pure decode of the current state (plus the Booth pair in
    // EVAL) and are all held low while the sequencer is frozen.
    always_comb begin
        c0   = 1'b0;
        c1   = 1'b0;
        c2   = 1'b0;
        c3   = 1'b0;
        c4   = 1'b0;
        c5   = 1'b0;
        c6   = 1'b0;
        c7   = 1'b0;
        done = 1'b0;
        if (en) begin
            case (r_state)
                c_LOAD_M: c0 = 1'b1;
                c_LOAD_Q: begin
                    c1 = 1'b1;
                    c2 = w_is_mul;
                end
                c_EVAL: begin
                    // 01 -> A+M, 10 -> A-M, 00/11 -> no add
                    c4 = booth_bits[0] ^ booth_bits[1];
                    c3 = booth_bits[1] & ~booth_bits[0];
                end
                c_SHIFT:  c5 = 1'b1;
                c_OUT_HI: c6 = 1'b1;
                c_OUT_LO: begin
                    c7   = 1'b1;
                    done = 1'b1;
                    c3   = (r_op == c_OP_SUB);
                end
                default: ;
            endcase
        end
    end

    assign busy  = (r_state != c_IDLE);
    assign state = r_state;
    assign cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq_ctrl
// Purpose  : Directed self-checking bench for alu_seq_ctrl (WIDTH=8) with a
//            behavioural A/Q/Q[-1]/M datapath driven by the DUT strobes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH);

    logic             clk;
    logic             rst;
    logic             en;
    logic             start;
    logic [1:0]       op;
    logic [1:0]       booth_bits;
    logic             c0, c1, c2, c3, c4, c5, c6, c7;
    logic             busy;
    logic             done;
    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;

    alu_seq_ctrl #(.WIDTH(WIDTH)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .start      (start),
        .op         (op),
        .booth_bits (booth_bits),
        .c0         (c0),
        .c1         (c1),
        .c2         (c2),
        .c3         (c3),
        .c4         (c4),
        .c5         (c5),
        .c6         (c6),
        .c7         (c7),
        .busy       (busy),
        .done       (done),
        .state      (state),
        .cnt        (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural datapath ----------------
    // A carries one guard bit so that A-M with M = most-negative value does
    // not wrap before the arithmetic shift.
    logic [WIDTH:0]   r_ma;
    logic [WIDTH-1:0] r_mq;
    logic             r_mq1;
    logic [WIDTH-1:0] r_mm;
    logic             r_mmul;
    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] opnd_b;
    logic [WIDTH-1:0] outbus;
    logic [WIDTH:0]   w_mx;
    logic [7:0]       strobes;

    assign w_mx       = {r_mm[WIDTH-1], r_mm};
    assign booth_bits = {r_mq[0], r_mq1};
    assign strobes    = {c7, c6, c5, c4, c3, c2, c1, c0};

    always_comb begin
        outbus = '0;
        if (c6)      outbus = r_ma[WIDTH-1:0];
        else if (c7) outbus = r_mmul ? r_mq : (c3 ? r_mm - r_mq : r_mm + r_mq);
    end

    always_ff @(posedge clk) begin
        if (c0) begin
            r_mm   <= opnd_a;
            r_mmul <= 1'b0;
        end
        if (c1) begin
            r_mq  <= opnd_b;
            r_mq1 <= 1'b0;
        end
        if (c2) begin
            r_ma   <= '0;
            r_mmul <= 1'b1;
        end
        if (c4) r_ma <= c3 ? r_ma - w_mx : r_ma + w_mx;
        if (c5) {r_ma, r_mq, r_mq1} <= {r_ma[WIDTH], r_ma, r_mq};
    end

    // ---------------- checking helpers ----------------
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // add/sub: strobe sequence c0, c1, c7 then IDLE. With hold_start the
    // start line stays high (and op is changed to mul) for the whole command.
    task automatic run_addsub(input string tag, input logic [7:0] a, input logic [7:0] b,
                              input logic [1:0] opv, input logic hold_start,
                              input logic [7:0] exp_out, input logic exp_c3);
        opnd_a = a;
        opnd_b = b;
        op     = opv;
        start  = 1'b1;
        cyc    = 0;
        step();
        if (hold_start) op = 2'b10;
        else            start = 1'b0;
        #1;
        chk({tag, "_cyc1_strobes"}, 16'(strobes), 16'h01);
        chk({tag, "_cyc1_state"}, 16'(state), 16'd1);
        chk({tag, "_cyc1_busy"}, 16'(busy), 16'd1);
        step();
        chk({tag, "_cyc2_strobes"}, 16'(strobes), 16'h02);
        step();
        chk({tag, "_cyc3_strobes"}, 16'(strobes), exp_c3 ? 16'h88 : 16'h80);
        chk({tag, "_cyc3_done"}, 16'(done), 16'd1);
        chk({tag, "_outbus"}, 16'(outbus), 16'(exp_out));
        chk({tag, "_done_cycle"}, 16'(cyc), 16'd3);
        start = 1'b0;
        step();
        chk({tag, "_after_busy"}, 16'(busy), 16'd0);
        chk({tag, "_after_done"}, 16'(done), 16'd0);
        chk({tag, "_after_state"}, 16'(state), 16'd0);
    endtask

    task automatic run_mul(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic freeze, input logic busy_start,
                           input logic [7:0] exp_hi, input logic [7:0] exp_lo, input int exp_cyc);
        int   shifts;
        logic got;
        logic frozen;
        logic [7:0] hi;
        logic [7:0] lo;
        int   dcyc;
        shifts = 0;
        got    = 1'b0;
        frozen = 1'b0;
        hi     = 8'h00;
        lo     = 8'h00;
        dcyc   = 0;
        opnd_a = a;
        opnd_b = b;
        op     = 2'b10;
        start  = 1'b1;
        cyc    = 0;
        step();
        start = 1'b0;
        #1;
        while (!got && cyc < 60) begin
            if (c5) shifts++;
            if (c6) hi = outbus;
            if (c7) lo = outbus;
            if (done) begin
                got  = 1'b1;
                dcyc = cyc;
            end
            // a command pulse while busy must be ignored
            if (busy_start && (cyc == 5 || cyc == 12)) begin
                start = 1'b1;
                op    = 2'b00;
            end else begin
                start = 1'b0;
            end
            if (!got) begin
                step();
                if (freeze && shifts == 4 && !frozen) begin
                    frozen = 1'b1;
                    en     = 1'b0;
                    #1;
                    repeat (3) begin
                        chk({tag, "_frz_state"}, 16'(state), 16'd3);
                        chk({tag, "_frz_cnt"}, 16'(cnt), 16'd4);
                        chk({tag, "_frz_strobes"}, 16'(strobes), 16'h00);
                        chk({tag, "_frz_busy"}, 16'(busy), 16'd1);
                        step();
                    end
                    en = 1'b1;
                    #1;
                end
            end
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 16'(got), 16'd1);
        chk({tag, "_shift_pulses"}, 16'(shifts), 16'd8);
        chk({tag, "_hi"}, 16'(hi), 16'(exp_hi));
        chk({tag, "_lo"}, 16'(lo), 16'(exp_lo));
        chk({tag, "_done_cycle"}, 16'(dcyc), 16'(exp_cyc));
        step();
        chk({tag, "_after_busy"}, 16'(busy), 16'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int guard;
        rst    = 1'b1;
        en     = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        opnd_a = '0;
        opnd_b = '0;
        step();
        step();
        chk("reset_state", 16'(state), 16'd0);
        chk("reset_cnt", 16'(cnt), 16'd0);
        chk("reset_busy", 16'(busy), 16'd0);
        chk("reset_strobes", 16'(strobes), 16'h00);
        chk("reset_done", 16'(done), 16'd0);
        rst = 1'b0;
        step();

        run_addsub("add", 8'd25, 8'd17, 2'b00, 1'b0, 8'd42, 1'b0);
        run_addsub("sub", 8'd5, 8'd9, 2'b01, 1'b0, 8'hFC, 1'b1);
        // start held through the whole command, op switched to mul after
        // acceptance: latched op must still select subtract
        run_addsub("sub_hold", 8'd100, 8'd30, 2'b01, 1'b1, 8'd70, 1'b1);

        run_mul("mul_7x-3", 8'd7, 8'hFD, 1'b0, 1'b0, 8'hFF, 8'hEB, 20);
        run_mul("mul_-128sq", 8'h80, 8'h80, 1'b0, 1'b0, 8'h40, 8'h00, 20);
        run_mul("mul_freeze", 8'd7, 8'hFD, 1'b1, 1'b0, 8'hFF, 8'hEB, 23);
        run_mul("mul_busystart", 8'd7, 8'hFD, 1'b0, 1'b1, 8'hFF, 8'hEB, 20);

        // reserved opcode is ignored
        op    = 2'b11;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("rsvd_state", 16'(state), 16'd0);
        chk("rsvd_busy", 16'(busy), 16'd0);
        step();
        chk("rsvd_state2", 16'(state), 16'd0);

        // reset in the middle of a multiply (EVAL, cnt=3)
        opnd_a = 8'd7;
        opnd_b = 8'hFD;
        op     = 2'b10;
        start  = 1'b1;
        step();
        start = 1'b0;
        guard = 0;
        while (!(state == 3'd3 && cnt == 3'd3) && guard < 30) begin
            step();
            guard++;
        end
        chk("rstmid_reached_eval3", 16'(state == 3'd3 && cnt == 3'd3), 16'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid_state", 16'(state), 16'd0);
        chk("rstmid_cnt", 16'(cnt), 16'd0);
        chk("rstmid_busy", 16'(busy), 16'd0);
        chk("rstmid_strobes", 16'(strobes), 16'h00);
        step();
        chk("rstmid_idle_hold", 16'(state), 16'd0);
        run_addsub("add_after_rst", 8'd200, 8'd100, 2'b00, 1'b0, 8'd44, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
